mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; byte-enable width is DATA_W/8.
REQ-003 The block SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to port 1 (debug).
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles for mem_ack; range 1..65535.
REQ-005 The block SHALL have port clk, input, 1, the single system clock.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port inhibit, input, 1; while high, no new grant is issued.
REQ-008 The block SHALL have ports req0/req1, input, 1 each, meaning request from port 0 (core) and port 1 (debug SBA).
REQ-009 The block SHALL have ports addr0/addr1, input, ADDR_W each; wdata0/wdata1, input, DATA_W each; we0/we1, input, 1 each; be0/be1, input, DATA_W/8 each.
REQ-010 The block SHALL have ports ack0/ack1, output, 1 each; err0/err1, output, 1 each; rdata0/rdata1, output, DATA_W each.
REQ-011 The block SHALL have memory-side ports mem_req (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_we (output, 1), mem_be (output, DATA_W/8), mem_rdata (input, DATA_W) and mem_ack (input, 1).

Function
REQ-012 The FSM SHALL have states IDLE, GRANT0 and GRANT1.
REQ-013 Requester protocol: reqN, addrN, wdataN, weN and beN SHALL be held stable by the requester until ackN; a requester deasserting early SHALL NOT abort a granted transaction.
REQ-014 In IDLE with inhibit=0: if exactly one reqN=1, the FSM SHALL move to GRANTN at the next clk edge; with none, it SHALL stay in IDLE.
REQ-015 On contention with RR=1, the grant SHALL go to the port not granted last, held in a last-grant register (reset value = 1, so port 0 wins the first tie); with RR=0, port 1 SHALL win.
REQ-016 In IDLE with inhibit=1, the FSM SHALL stay in IDLE regardless of requests; inhibit SHALL NOT affect a transaction already in GRANTx.
REQ-017 In GRANTN: mem_req=1; mem_addr, mem_wdata, mem_we and mem_be SHALL equal port N's inputs; in IDLE, mem_req=0 and the other mem_* outputs SHALL be 0.
REQ-018 In GRANTN, ackN SHALL equal mem_ack combinationally, and the other port's ack SHALL be 0.
REQ-019 rdataN SHALL equal mem_rdata while ackN=1, and 0 otherwise.
REQ-020 On mem_ack=1 in GRANTN, the FSM SHALL return to IDLE at that edge and update last-grant to N; minimum occupancy is 2 cycles (1 grant + 1 idle bubble).
REQ-021 A wait counter SHALL clear on entry to GRANTx and increment each GRANTx cycle with mem_ack=0.
REQ-022 When the wait counter equals TIMEOUT, the block SHALL pulse ackN=1 and errN=1 for one cycle, drive rdataN=0 and return to IDLE; mem_ack arriving in that same cycle SHALL take precedence (errN=0, normal completion).
REQ-023 errN SHALL be 0 in every cycle except a timeout completion.
REQ-024 At most one of ack0 and ack1 SHALL be 1 in any cycle.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force IDLE, last-grant=1, wait counter=0, and mem_req, ack0, ack1, err0 and err1 = 0, asynchronously and including mid-transaction.
REQ-026 After rst_n rises, arbitration SHALL begin on the first clk edge at which rst_n=1 is sampled.
REQ-027 No memory transaction aborted by reset SHALL be acknowledged after reset.

Verification
REQ-028 Single read: req0=1, addr0=0x100, we0=0, with mem_ack=1 and mem_rdata=0xDEADBEEF one cycle after mem_req -> mem_addr=0x100, ack0=1 and rdata0=0xDEADBEEF for exactly 1 cycle; ack1 stays 0.
REQ-029 Contention: req0 and req1 held high with RR=1 and mem_ack always 1 -> grants alternate 0,1,0,1; with RR=0 -> port 1 is granted every time.
REQ-030 Inhibit: inhibit=1 for 3 cycles with req1=1 -> mem_req stays 0; the grant follows within 1 edge of inhibit falling; inhibit rising during GRANT1 does not stop ack1.
REQ-031 Timeout: TIMEOUT=4 with mem_ack held 0 -> ack0=1 and err0=1 on the 5th GRANT0 cycle, followed by mem_req=0.
REQ-032 Reset mid-transaction: rst_n=0 while in GRANT1 -> mem_req=0 with no clk edge; after release with req1 still high, a fresh GRANT1 is issued and there is no stale ack.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port memory arbiter (core port 0, debug SBA port 1) with
//            round-robin or fixed-priority selection, inhibit gating and
//            an ack-wait timeout that completes the access with an error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inhibit,
    // port 0 (core)
    input  logic                req0,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic                we0,
    input  logic [DATA_W/8-1:0] be0,
    output logic                ack0,
    output logic                err0,
    output logic [DATA_W-1:0]   rdata0,
    // port 1 (debug SBA)
    input  logic                req1,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata1,
    input  logic                we1,
    input  logic [DATA_W/8-1:0] be1,
    output logic                ack1,
    output logic                err1,
    output logic [DATA_W-1:0]   rdata1,
    // memory side
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;    // port granted most recently
    logic [15:0] r_wait;    // cycles spent waiting for mem_ack
    logic        w_tout;    // wait budget exhausted with no mem_ack this cycle
    logic        w_done;    // current grant completes at the next edge

    // Timeout only fires when mem_ack is absent, so a late ack still wins.
    assign w_tout = (r_wait == c_TIMEOUT) && !mem_ack;
    assign w_done = (r_state != IDLE) && (mem_ack || w_tout);

    // State register; reset drops any in-flight grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Remember the completed port so the next tie goes to the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_done) begin
            r_last <= (r_state == GRANT1);
        end
    end

    // Wait counter: held at zero while idle, so it is clear on grant entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 16'd0;
        end else if (r_state == IDLE) begin
            r_wait <= 16'd0;
        end else if (!mem_ack && (r_wait != c_TIMEOUT)) begin
            r_wait <= r_wait + 16'd1;
        end
    end

    // Next-state selection and the memory/requester muxes.
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        ack0      = 1'b0;
        err0      = 1'b0;
        rdata0    = '0;
        ack1      = 1'b0;
        err1      = 1'b0;
        rdata1    = '0;
        case (r_state)
            IDLE: begin
                if (!inhibit) begin
                    if (req0 && req1) begin
                        // Round-robin favours the port not served last;
                        // fixed priority always serves the debug port.
                        w_next = ((RR != 0) && r_last) ? GRANT0 : GRANT1;
                    end else if (req0) begin
                        w_next = GRANT0;
                    end else if (req1) begin
                        w_next = GRANT1;
                    end
                end
            end
            GRANT0: begin
                mem_req   = 1'b1;
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_we    = we0;
                mem_be    = be0;
                ack0      = mem_ack || w_tout;
                err0      = w_tout;
                rdata0    = mem_ack ? mem_rdata : '0;
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            GRANT1: begin
                mem_req   = 1'b1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_we    = we1;
                mem_be    = be1;
                ack1      = mem_ack || w_tout;
                err1      = w_tout;
                rdata1    = mem_ack ? mem_rdata : '0;
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed vector table,
//            hand sequences for contention and async reset, and random
//            traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inhibit;
    logic          req0, req1, we0, we1, mem_ack;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, mem_rdata;
    logic [BW-1:0] be0, be1;

    // round-robin instance outputs
    logic          ack0, ack1, err0, err1, mem_req, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;

    // fixed-priority instance outputs
    logic          fp_ack0, fp_ack1, fp_err0, fp_err1, fp_mem_req, fp_mem_we;
    logic [DW-1:0] fp_rdata0, fp_rdata1, fp_mem_wdata;
    logic [AW-1:0] fp_mem_addr;
    logic [BW-1:0] fp_mem_be;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .inhibit(inhibit),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .be0(be0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .be1(be1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst_n(rst_n), .inhibit(inhibit),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .be0(be0),
        .ack0(fp_ack0), .err0(fp_err0), .rdata0(fp_rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .be1(be1),
        .ack1(fp_ack1), .err1(fp_err1), .rdata1(fp_rdata1),
        .mem_req(fp_mem_req), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_we(fp_mem_we), .mem_be(fp_mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic          r0, r1, inh, mack;
        logic          e_req, e_a0, e_a1, e_e0, e_e1;
        logic [AW-1:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic r0, r1, inh, mack,
                                input logic e_req, e_a0, e_a1, e_e0, e_e1,
                                input logic [AW-1:0] e_addr);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.inh = inh; v.mack = mack;
        v.e_req = e_req; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_e0 = e_e0; v.e_e1 = e_e1;
        v.e_addr = e_addr;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner of the memory (-1 = nobody), cycles waited,
    // and which port was served last.
    // ------------------------------------------------------------------
    int m_owner, m_wait, m_last;

    initial begin
        vec_t tbl[$];
        int   gcount;
        logic p0, p1;

        rst_n = 1'b0; inhibit = 0; req0 = 0; req1 = 0; mem_ack = 0;
        addr0 = 32'h100; addr1 = 32'h200;
        wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
        we0 = 0; we1 = 1; be0 = 4'hF; be1 = 4'h3;
        mem_rdata = 32'hDEAD_BEEF;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_err", {err0, err1}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;

        // ---------------- directed vector table (RR, last=1 after reset) ----
        //            r0 r1 in mk  req a0 a1 e0 e1 addr
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 32'h0));   // tie -> port 0
        tbl.push_back(mk(1, 1, 0, 1,  1, 1, 0, 0, 0, 32'h100)); // single read ack
        tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 32'h0));   // bubble, tie -> port 1
        tbl.push_back(mk(1, 1, 0, 1,  1, 0, 1, 0, 0, 32'h200));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0, 0, 0, 0, 32'h0));   // inhibit x3
        tbl.push_back(mk(0, 1, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 32'h0));   // inhibit falls
        tbl.push_back(mk(0, 1, 1, 1,  1, 0, 1, 0, 0, 32'h200)); // inhibit mid-grant
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 32'h100)); // waits 0..3
        tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 32'h100));
        tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 32'h100));
        tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 32'h100));
        tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 1, 0, 32'h100)); // 5th cycle: timeout
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 32'h200));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 32'h200));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 32'h200));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 32'h200));
        tbl.push_back(mk(0, 1, 0, 1,  1, 0, 1, 0, 0, 32'h200)); // ack beats timeout
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            inhibit = tbl[i].inh; mem_ack = tbl[i].mack;
            #1;
            chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_ack0", i), ack0, tbl[i].e_a0);
            chk($sformatf("tbl%0d_ack1", i), ack1, tbl[i].e_a1);
            chk($sformatf("tbl%0d_err0", i), err0, tbl[i].e_e0);
            chk($sformatf("tbl%0d_err1", i), err1, tbl[i].e_e1);
            chk($sformatf("tbl%0d_rdata0", i), rdata0,
                (tbl[i].e_a0 && !tbl[i].e_e0) ? 32'hDEAD_BEEF : 32'h0);
            chk($sformatf("tbl%0d_rdata1", i), rdata1,
                (tbl[i].e_a1 && !tbl[i].e_e1) ? 32'hDEAD_BEEF : 32'h0);
            @(posedge clk);
            #1;
        end

        // ---------------- contention: RR alternates, fixed gives port 1 ----
        req0 = 0; req1 = 0; mem_ack = 0; inhibit = 0;
        do_reset();
        req0 = 1; req1 = 1; mem_ack = 1;
        gcount = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ack0 || ack1) begin
                chk($sformatf("rr_grant%0d_port", gcount), {ack1, ack0},
                    (gcount % 2 == 0) ? 2'b01 : 2'b10);
                gcount++;
            end
            if (fp_mem_req) begin
                chk($sformatf("fp_grant_c%0d", c), {fp_ack1, fp_ack0}, 2'b10);
            end
            @(posedge clk);
            #1;
        end
        chk("rr_grant_count", gcount, 6);

        // ---------------- async reset during GRANT1 ----------------
        req0 = 0; req1 = 0; mem_ack = 0;
        do_reset();
        req1 = 1;
        @(posedge clk);
        #1;
        chk("arst_pre_mem_req", mem_req, 1);
        #2;
        rst_n = 0; mem_ack = 1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_ack1", ack1, 0);
        chk("arst_err1", err1, 0);
        @(posedge clk);
        #1;
        rst_n = 1; mem_ack = 0;
        #1;
        chk("arst_rel_idle", mem_req, 0);
        @(posedge clk);
        #1;
        chk("arst_regrant_req", mem_req, 1);
        chk("arst_regrant_addr", mem_addr, 32'h200);
        chk("arst_no_stale_ack", ack1, 0);
        mem_ack = 1;
        #1;
        chk("arst_fresh_ack1", ack1, 1);
        @(posedge clk);
        #1;
        req1 = 0; mem_ack = 0;
        #1;
        chk("arst_done_idle", mem_req, 0);

        // ---------------- random traffic vs reference model ----------------
        do_reset();
        m_owner = -1; m_wait = 0; m_last = 1;
        p0 = 0; p1 = 0;
        for (int c = 0; c < 400; c++) begin
            logic          x_tout, x_a0, x_a1;
            logic [AW-1:0] x_addr;
            logic [DW-1:0] x_wd;
            logic          x_we;
            logic [BW-1:0] x_be;
            int            n_owner;

            if (!p0 && ($urandom_range(2) == 0)) begin
                p0 = 1; addr0 = $urandom; wdata0 = $urandom;
                we0 = 1'($urandom); be0 = 4'($urandom);
            end
            if (!p1 && ($urandom_range(2) == 0)) begin
                p1 = 1; addr1 = $urandom; wdata1 = $urandom;
                we1 = 1'($urandom); be1 = 4'($urandom);
            end
            req0 = p0; req1 = p1;
            inhibit   = ($urandom_range(4) == 0);
            mem_ack   = ($urandom_range(2) == 0);
            mem_rdata = $urandom;
            #1;

            x_tout = (m_owner >= 0) && (m_wait == TO) && !mem_ack;
            x_a0   = (m_owner == 0) && (mem_ack || x_tout);
            x_a1   = (m_owner == 1) && (mem_ack || x_tout);
            x_addr = (m_owner == 0) ? addr0  : (m_owner == 1) ? addr1  : '0;
            x_wd   = (m_owner == 0) ? wdata0 : (m_owner == 1) ? wdata1 : '0;
            x_we   = (m_owner == 0) ? we0    : (m_owner == 1) ? we1    : 1'b0;
            x_be   = (m_owner == 0) ? be0    : (m_owner == 1) ? be1    : '0;

            chk("rnd_mem_req", mem_req, m_owner >= 0);
            chk("rnd_mem_addr", mem_addr, x_addr);
            chk("rnd_mem_wdata", mem_wdata, x_wd);
            chk("rnd_mem_we", mem_we, x_we);
            chk("rnd_mem_be", mem_be, x_be);
            chk("rnd_ack0", ack0, x_a0);
            chk("rnd_ack1", ack1, x_a1);
            chk("rnd_err0", err0, x_a0 && x_tout);
            chk("rnd_err1", err1, x_a1 && x_tout);
            chk("rnd_rdata0", rdata0, (x_a0 && mem_ack) ? mem_rdata : 32'h0);
            chk("rnd_rdata1", rdata1, (x_a1 && mem_ack) ? mem_rdata : 32'h0);

            // advance the model by one clock
            n_owner = m_owner;
            if (m_owner < 0) begin
                if (!inhibit) begin
                    if (req0 && req1) n_owner = 1 - m_last;
                    else if (req0)    n_owner = 0;
                    else if (req1)    n_owner = 1;
                end
                m_wait = 0;
            end else if (x_a0 || x_a1) begin
                m_last  = m_owner;
                n_owner = -1;
                m_wait  = 0;
            end else begin
                m_wait = m_wait + 1;
            end
            @(posedge clk);
            m_owner = n_owner;
            if (x_a0) p0 = 0;
            if (x_a1) p1 = 0;
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
